// File: rtl/mem_to_axi.sv
// Memory-stream slave (req/gnt/rvalid) issuing single-beat AXI4+ATOP master transactions.
// Optional macro MEM_TO_AXI_ATOP_EN forwards mem_atop_i and tracks atomics needing both R and B.

typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [5:0]  atop;
    logic [0:0]  user;
} mem_to_axi_aw_chan_t;

typedef struct packed {
    logic [31:0] data;
    logic [3:0]  strb;
    logic        last;
    logic [0:0]  user;
} mem_to_axi_w_chan_t;

typedef struct packed {
    logic [3:0]  id;
    logic [1:0]  resp;
    logic [0:0]  user;
} mem_to_axi_b_chan_t;

typedef struct packed {
    logic [3:0]  id;
    logic [31:0] addr;
    logic [7:0]  len;
    logic [2:0]  size;
    logic [1:0]  burst;
    logic        lock;
    logic [3:0]  cache;
    logic [2:0]  prot;
    logic [3:0]  qos;
    logic [3:0]  region;
    logic [0:0]  user;
} mem_to_axi_ar_chan_t;

typedef struct packed {
    logic [3:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
    logic [0:0]  user;
} mem_to_axi_r_chan_t;

typedef struct packed {
    mem_to_axi_aw_chan_t aw;
    logic                aw_valid;
    mem_to_axi_w_chan_t  w;
    logic                w_valid;
    logic                b_ready;
    mem_to_axi_ar_chan_t ar;
    logic                ar_valid;
    logic                r_ready;
} mem_to_axi_req_t;

typedef struct packed {
    logic                aw_ready;
    logic                ar_ready;
    logic                w_ready;
    logic                b_valid;
    mem_to_axi_b_chan_t  b;
    logic                r_valid;
    mem_to_axi_r_chan_t  r;
} mem_to_axi_resp_t;

module mem_to_axi #(
    parameter type                axi_req_t  = mem_to_axi_req_t,
    parameter type                axi_resp_t = mem_to_axi_resp_t,
    parameter int unsigned        AddrWidth  = 32,
    parameter int unsigned        DataWidth  = 32,
    parameter int unsigned        IdWidth    = 4,
    parameter logic [IdWidth-1:0] AxiId      = '0,
    parameter int unsigned        MaxTrans   = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    output logic                   busy_o,
    input  logic                   mem_req_i,
    output logic                   mem_gnt_o,
    input  logic [AddrWidth-1:0]   mem_addr_i,
    input  logic [DataWidth-1:0]   mem_wdata_i,
    input  logic [DataWidth/8-1:0] mem_strb_i,
    input  logic                   mem_we_i,
    input  logic [5:0]             mem_atop_i,
    output logic                   mem_rvalid_o,
    output logic [DataWidth-1:0]   mem_rdata_o,
    output logic                   mem_err_o,
    output axi_req_t               axi_req_o,
    input  axi_resp_t              axi_resp_i
);
    localparam int unsigned StrbWidth = DataWidth / 8;
    localparam logic [2:0]  AxSize    = 3'($clog2(StrbWidth));
    localparam int unsigned PtrWidth  = (MaxTrans > 1) ? $clog2(MaxTrans) : 1;
    localparam int unsigned CntWidth  = $clog2(MaxTrans + 1);
    localparam logic [CntWidth-1:0] MaxCnt  = CntWidth'(MaxTrans);
    localparam logic [PtrWidth-1:0] LastPtr = PtrWidth'(MaxTrans - 1);

    typedef enum logic [1:0] {IDLE, WR, RD} state_e;

    typedef enum logic [1:0] {
        T_READ,
        T_WRITE
`ifdef MEM_TO_AXI_ATOP_EN
        , T_ATOMIC
`endif
    } entry_e;

    // Handshakes on both sides are strict valid/ready: a transfer happens on a
    // rising edge where valid and ready are both high; a raised valid stays up,
    // with its payload stable, until that transfer; ready may depend on valid,
    // valid never depends on ready. mem_gnt_o acts as the ready of mem_req_i.

    state_e                 state_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [StrbWidth-1:0]   strb_q;
    logic                   aw_valid_q, w_valid_q, ar_valid_q;
    logic                   aw_done_q, w_done_q;
`ifdef MEM_TO_AXI_ATOP_EN
    logic [5:0]             atop_q;
    logic                   r_seen_q, b_seen_q;
    logic [DataWidth-1:0]   atom_data_q;
    logic                   atom_err_q;
`endif

    entry_e                 fifo_q [MaxTrans];
    logic [PtrWidth-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CntWidth-1:0]    cnt_q;

    logic                   rvalid_q;
    logic [DataWidth-1:0]   rdata_q;
    logic                   err_q;

    logic                   order_full, order_empty, gnt, pop;
    entry_e                 head, push_type;
    logic                   aw_hs, w_hs, ar_hs, r_hs, b_hs;
    logic                   r_ready, b_ready;
    logic [DataWidth-1:0]   rsp_data;
    logic                   rsp_err;

    function automatic logic [PtrWidth-1:0] ptr_inc(input logic [PtrWidth-1:0] p);
        return (p == LastPtr) ? '0 : p + PtrWidth'(1);
    endfunction

    assign order_full  = (cnt_q == MaxCnt);
    assign order_empty = (cnt_q == '0);
    assign head        = fifo_q[rd_ptr_q];

    // A pop in the same cycle deliberately does not free a slot for the grant.
    assign gnt       = rst_ni & (state_q == IDLE) & mem_req_i & ~order_full;
    assign mem_gnt_o = gnt;

    assign aw_hs = aw_valid_q & axi_resp_i.aw_ready;
    assign w_hs  = w_valid_q  & axi_resp_i.w_ready;
    assign ar_hs = ar_valid_q & axi_resp_i.ar_ready;
    assign r_hs  = axi_resp_i.r_valid & r_ready;
    assign b_hs  = axi_resp_i.b_valid & b_ready;

    always_comb begin
        push_type = mem_we_i ? T_WRITE : T_READ;
`ifdef MEM_TO_AXI_ATOP_EN
        if (mem_we_i && mem_atop_i[5]) push_type = T_ATOMIC;
`endif
    end

    // Only the channel matching the oldest outstanding entry is accepted.
    always_comb begin
        r_ready  = 1'b0;
        b_ready  = 1'b0;
        pop      = 1'b0;
        rsp_data = '0;
        rsp_err  = 1'b0;
        if (!order_empty) begin
            case (head)
                T_READ: begin
                    r_ready  = 1'b1;
                    pop      = r_hs;
                    rsp_data = axi_resp_i.r.data[DataWidth-1:0];
                    rsp_err  = axi_resp_i.r.resp[1];
                end
                T_WRITE: begin
                    b_ready  = 1'b1;
                    pop      = b_hs;
                    rsp_err  = axi_resp_i.b.resp[1];
                end
`ifdef MEM_TO_AXI_ATOP_EN
                T_ATOMIC: begin
                    r_ready  = ~r_seen_q;
                    b_ready  = ~b_seen_q;
                    pop      = (r_seen_q | r_hs) & (b_seen_q | b_hs);
                    rsp_data = r_hs ? axi_resp_i.r.data[DataWidth-1:0] : atom_data_q;
                    rsp_err  = atom_err_q | (r_hs & axi_resp_i.r.resp[1])
                                          | (b_hs & axi_resp_i.b.resp[1]);
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        axi_req_o = '0;
        axi_req_o.aw.id[IdWidth-1:0]     = AxiId;
        axi_req_o.aw.addr[AddrWidth-1:0] = addr_q;
        axi_req_o.aw.len   = 8'd0;
        axi_req_o.aw.size  = AxSize;
        axi_req_o.aw.burst = 2'b01;
        axi_req_o.aw.cache = 4'b0010;
`ifdef MEM_TO_AXI_ATOP_EN
        axi_req_o.aw.atop  = atop_q;
`else
        axi_req_o.aw.atop  = 6'd0;
`endif
        axi_req_o.aw_valid = aw_valid_q;
        axi_req_o.w.data[DataWidth-1:0] = wdata_q;
        axi_req_o.w.strb[StrbWidth-1:0] = strb_q;
        axi_req_o.w.last   = 1'b1;
        axi_req_o.w_valid  = w_valid_q;
        axi_req_o.b_ready  = b_ready;
        axi_req_o.ar.id[IdWidth-1:0]     = AxiId;
        axi_req_o.ar.addr[AddrWidth-1:0] = addr_q;
        axi_req_o.ar.len   = 8'd0;
        axi_req_o.ar.size  = AxSize;
        axi_req_o.ar.burst = 2'b01;
        axi_req_o.ar.cache = 4'b0010;
        axi_req_o.ar_valid = ar_valid_q;
        axi_req_o.r_ready  = r_ready;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            wdata_q    <= '0;
            strb_q     <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            ar_valid_q <= 1'b0;
            aw_done_q  <= 1'b0;
            w_done_q   <= 1'b0;
`ifdef MEM_TO_AXI_ATOP_EN
            atop_q     <= '0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (gnt) begin
                        addr_q  <= mem_addr_i;
                        wdata_q <= mem_wdata_i;
                        strb_q  <= mem_strb_i;
`ifdef MEM_TO_AXI_ATOP_EN
                        atop_q  <= mem_we_i ? mem_atop_i : 6'd0;
`endif
                        if (mem_we_i) begin
                            state_q    <= WR;
                            aw_valid_q <= 1'b1;
                            w_valid_q  <= 1'b1;
                            aw_done_q  <= 1'b0;
                            w_done_q   <= 1'b0;
                        end else begin
                            state_q    <= RD;
                            ar_valid_q <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (aw_hs) aw_valid_q <= 1'b0;
                    if (w_hs)  w_valid_q  <= 1'b0;
                    aw_done_q <= aw_done_q | aw_hs;
                    w_done_q  <= w_done_q | w_hs;
                    if ((aw_done_q | aw_hs) && (w_done_q | w_hs)) begin
                        state_q   <= IDLE;
                        aw_done_q <= 1'b0;
                        w_done_q  <= 1'b0;
                    end
                end
                RD: begin
                    if (ar_hs) begin
                        ar_valid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (gnt) fifo_q[wr_ptr_q] <= push_type;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            if (gnt) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
            cnt_q <= cnt_q + CntWidth'(gnt) - CntWidth'(pop);
        end
    end

`ifdef MEM_TO_AXI_ATOP_EN
    // Partial results of the head atomic until its second response arrives.
    always_ff @(posedge clk_i) begin
        if (!rst_ni || pop) begin
            r_seen_q    <= 1'b0;
            b_seen_q    <= 1'b0;
            atom_data_q <= '0;
            atom_err_q  <= 1'b0;
        end else if (!order_empty && head == T_ATOMIC) begin
            if (r_hs) begin
                r_seen_q    <= 1'b1;
                atom_data_q <= axi_resp_i.r.data[DataWidth-1:0];
            end
            if (b_hs) b_seen_q <= 1'b1;
            atom_err_q <= atom_err_q | (r_hs & axi_resp_i.r.resp[1])
                                     | (b_hs & axi_resp_i.b.resp[1]);
        end
    end
`endif

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= pop;
            if (pop) begin
                rdata_q <= rsp_data;
                err_q   <= rsp_err;
            end
        end
    end

    assign mem_rvalid_o = rvalid_q;
    assign mem_rdata_o  = rdata_q;
    assign mem_err_o    = err_q;
    assign busy_o       = (state_q != IDLE) | ~order_empty;

    logic unused_ok;
    assign unused_ok = ^{axi_resp_i.b.id, axi_resp_i.b.user, axi_resp_i.b.resp[0],
                         axi_resp_i.r.id, axi_resp_i.r.user, axi_resp_i.r.resp[0],
                         axi_resp_i.r.last
`ifndef MEM_TO_AXI_ATOP_EN
                         , mem_atop_i
`endif
                        };

endmodule

// File: tb/tb_mem_to_axi.sv
// Directed bench for mem_to_axi: scripted AXI slave, expected responses queued at grant time.
module tb_mem_to_axi;
    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;
    localparam int unsigned IW = 4;
    localparam int unsigned MT = 4;
    localparam logic [IW-1:0] ID = 4'h3;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            busy;
    logic            mem_req, mem_gnt, mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_strb;
    logic [5:0]      mem_atop;
    logic            mem_rvalid, mem_err;
    logic [DW-1:0]   mem_rdata;
    mem_to_axi_req_t  axi_req;
    mem_to_axi_resp_t axi_resp;

    int total = 0;
    int bad = 0;
    int aw_cnt = 0;
    int w_cnt = 0;
    logic [DW:0] exp_q[$];

    mem_to_axi #(
        .axi_req_t (mem_to_axi_req_t),
        .axi_resp_t(mem_to_axi_resp_t),
        .AddrWidth (AW),
        .DataWidth (DW),
        .IdWidth   (IW),
        .AxiId     (ID),
        .MaxTrans  (MT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .busy_o      (busy),
        .mem_req_i   (mem_req),
        .mem_gnt_o   (mem_gnt),
        .mem_addr_i  (mem_addr),
        .mem_wdata_i (mem_wdata),
        .mem_strb_i  (mem_strb),
        .mem_we_i    (mem_we),
        .mem_atop_i  (mem_atop),
        .mem_rvalid_o(mem_rvalid),
        .mem_rdata_o (mem_rdata),
        .mem_err_o   (mem_err),
        .axi_req_o   (axi_req),
        .axi_resp_i  (axi_resp)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: every mem response pops the oldest expectation
    always @(negedge clk) begin
        if (rst_n && mem_rvalid) begin
            check("rsp_available", 64'(exp_q.size() > 0), 64'd1);
            if (exp_q.size() > 0) check("rsp", 64'({mem_err, mem_rdata}), 64'(exp_q.pop_front()));
        end
    end

    always @(posedge clk) begin
        if (axi_req.aw_valid && axi_resp.aw_ready) aw_cnt <= aw_cnt + 1;
        if (axi_req.w_valid && axi_resp.w_ready) w_cnt <= w_cnt + 1;
    end

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic mem_issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                             input logic [5:0] atop, output logic granted);
        granted   = 1'b0;
        mem_req   = 1'b1;
        mem_we    = we;
        mem_addr  = addr;
        mem_wdata = wdata;
        mem_strb  = 4'hF;
        mem_atop  = atop;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (mem_gnt) begin
                granted = 1'b1;
                break;
            end
            tick();
        end
        tick();
        mem_req = 1'b0;
    endtask

    task automatic send_r(input logic [DW-1:0] data, input logic [1:0] resp);
        logic ok;
        ok = 1'b0;
        axi_resp.r_valid = 1'b1;
        axi_resp.r.data  = data;
        axi_resp.r.resp  = resp;
        axi_resp.r.last  = 1'b1;
        axi_resp.r.id    = ID;
        for (int i = 0; i < 20; i++) begin
            if (axi_req.r_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        axi_resp.r_valid = 1'b0;
        check("r_accepted", 64'(ok), 64'd1);
    endtask

    task automatic send_b(input logic [1:0] resp);
        logic ok;
        ok = 1'b0;
        axi_resp.b_valid = 1'b1;
        axi_resp.b.resp  = resp;
        axi_resp.b.id    = ID;
        for (int i = 0; i < 20; i++) begin
            if (axi_req.b_ready) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        tick();
        axi_resp.b_valid = 1'b0;
        check("b_accepted", 64'(ok), 64'd1);
    endtask

    initial begin
        logic g;
        logic seen;
        int aw0, w0;

        rst_n = 1'b0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = '0; mem_wdata = '0; mem_strb = '0; mem_atop = '0;
        axi_resp = '0;
        tick(); tick();
        check("rst_gnt", 64'(mem_gnt), 64'd0);
        check("rst_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}), 64'd0);
        check("rst_readies", 64'({axi_req.r_ready, axi_req.b_ready}), 64'd0);
        check("rst_rsp", 64'({mem_rvalid, mem_err, mem_rdata}), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        mem_req = 1'b0;
        rst_n = 1'b1;
        tick();

        // 1: single read, R three cycles after AR
        exp_q.push_back({1'b0, 32'hDEADBEEF});
        mem_issue(1'b0, 16'h0040, '0, 6'h0, g);
        check("t1_gnt", 64'(g), 64'd1);
        check("t1_ar_valid", 64'(axi_req.ar_valid), 64'd1);
        check("t1_ar_addr", 64'(axi_req.ar.addr), 64'h40);
        check("t1_ar_len_size_burst", 64'({axi_req.ar.len, axi_req.ar.size, axi_req.ar.burst}), 64'({8'd0, 3'd2, 2'd1}));
        check("t1_ar_id_cache", 64'({axi_req.ar.id, axi_req.ar.cache}), 64'({ID, 4'b0010}));
        check("t1_no_write", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'd0);
        check("t1_busy", 64'(busy), 64'd1);
        axi_resp.ar_ready = 1'b1;
        tick();
        axi_resp.ar_ready = 1'b0;
        check("t1_ar_drop", 64'(axi_req.ar_valid), 64'd0);
        tick(); tick(); tick();
        check("t1_b_ready", 64'(axi_req.b_ready), 64'd0);
        send_r(32'hDEADBEEF, 2'b00);
        check("t1_rvalid", 64'(mem_rvalid), 64'd1);
        tick();
        check("t1_rvalid_pulse", 64'(mem_rvalid), 64'd0);
        check("t1_idle", 64'(busy), 64'd0);

        // 2: write, W accepted two cycles before AW
        exp_q.push_back({1'b0, 32'h0});
        aw0 = aw_cnt; w0 = w_cnt;
        mem_issue(1'b1, 16'h0080, 32'h12345678, 6'h0, g);
        check("t2_gnt", 64'(g), 64'd1);
        check("t2_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}), 64'b110);
        check("t2_aw_addr", 64'(axi_req.aw.addr), 64'h80);
        check("t2_aw_len_atop", 64'({axi_req.aw.len, axi_req.aw.atop}), 64'd0);
        check("t2_w", 64'({axi_req.w.data, axi_req.w.strb, axi_req.w.last}), 64'({32'h12345678, 4'hF, 1'b1}));
        axi_resp.w_ready = 1'b1;
        tick();
        axi_resp.w_ready = 1'b0;
        check("t2_w_drop", 64'({axi_req.aw_valid, axi_req.w_valid}), 64'b10);
        tick();
        axi_resp.aw_ready = 1'b1;
        tick();
        axi_resp.aw_ready = 1'b0;
        check("t2_aw_drop", 64'(axi_req.aw_valid), 64'd0);
        check("t2_hs_count", 64'({16'(aw_cnt - aw0), 16'(w_cnt - w0)}), 64'h0001_0001);
        check("t2_readies", 64'({axi_req.b_ready, axi_req.r_ready}), 64'b10);
        send_b(2'b00);
        check("t2_rvalid", 64'(mem_rvalid), 64'd1);
        tick();
        check("t2_rvalid_pulse", 64'(mem_rvalid), 64'd0);

        // 3: fill the order FIFO with reads, R withheld
        axi_resp.ar_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            exp_q.push_back({1'b0, 32'hA000_0000 + 32'(k)});
            mem_issue(1'b0, 16'(16'h0100 + 4 * k), '0, 6'h0, g);
            check("t3_gnt", 64'(g), 64'd1);
        end
        tick(); tick();
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0200;
        seen = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (mem_gnt) seen = 1'b1;
            tick();
        end
        check("t3_full_blocks", 64'(seen), 64'd0);
        axi_resp.r_valid = 1'b1; axi_resp.r.data = 32'hA000_0000; axi_resp.r.resp = 2'b00;
        #1;
        check("t3_r_ready", 64'(axi_req.r_ready), 64'd1);
        check("t3_pop_no_bypass", 64'(mem_gnt), 64'd0);
        tick();
        axi_resp.r_valid = 1'b0;
        #1;
        check("t3_gnt_after_pop", 64'(mem_gnt), 64'd1);
        exp_q.push_back({1'b0, 32'hA000_0004});
        tick();
        mem_req = 1'b0;
        tick();
        for (int k = 1; k < 5; k++) send_r(32'hA000_0000 + 32'(k), 2'b00);
        axi_resp.ar_ready = 1'b0;
        tick();
        check("t3_idle", 64'(busy), 64'd0);

        // 4: write then read; R presented before B must wait
        axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1; axi_resp.ar_ready = 1'b1;
        aw0 = aw_cnt; w0 = w_cnt;
        exp_q.push_back({1'b0, 32'h0});
        mem_issue(1'b1, 16'h0300, 32'hCAFE0001, 6'h0, g);
        tick();
        check("t4_simul_hs", 64'({axi_req.aw_valid, axi_req.w_valid, 16'(aw_cnt - aw0), 16'(w_cnt - w0)}), 64'h0001_0001);
        exp_q.push_back({1'b0, 32'h5EED0004});
        mem_issue(1'b0, 16'h0304, '0, 6'h0, g);
        check("t4_rd_gnt", 64'(g), 64'd1);
        tick();
        axi_resp.r_valid = 1'b1; axi_resp.r.data = 32'h5EED0004; axi_resp.r.resp = 2'b00;
        seen = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            if (axi_req.r_ready || mem_rvalid) seen = 1'b1;
            tick();
        end
        check("t4_r_held", 64'(seen), 64'd0);
        axi_resp.b_valid = 1'b1; axi_resp.b.resp = 2'b00;
        #1;
        check("t4_only_head", 64'({axi_req.b_ready, axi_req.r_ready}), 64'b10);
        tick();
        axi_resp.b_valid = 1'b0;
        check("t4_wr_rsp", 64'(mem_rvalid), 64'd1);
        check("t4_r_ready_now", 64'(axi_req.r_ready), 64'd1);
        tick();
        axi_resp.r_valid = 1'b0;
        check("t4_rd_rsp", 64'(mem_rvalid), 64'd1);
        tick();
        check("t4_done", 64'({mem_rvalid, busy}), 64'd0);

        // 5: error responses, then reset in the middle of a write
        exp_q.push_back({1'b1, 32'hBAD0BAD0});
        mem_issue(1'b0, 16'h0400, '0, 6'h0, g);
        tick();
        send_r(32'hBAD0BAD0, 2'b11);
        check("t5_decerr", 64'({mem_rvalid, mem_err}), 64'b11);
        tick();
        exp_q.push_back({1'b1, 32'h0});
        mem_issue(1'b1, 16'h0404, 32'h0BADF00D, 6'h0, g);
        tick();
        send_b(2'b10);
        check("t5_slverr", 64'({mem_rvalid, mem_err}), 64'b11);
        tick();
        axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0; axi_resp.ar_ready = 1'b0;
        mem_issue(1'b1, 16'h0500, 32'h55555555, 6'h0, g);
        check("t5_in_wr", 64'({axi_req.aw_valid, axi_req.w_valid, busy}), 64'b111);
        rst_n = 1'b0;
        mem_req = 1'b1;
        tick();
        check("t5_rst_valids", 64'({axi_req.aw_valid, axi_req.w_valid, axi_req.ar_valid}), 64'd0);
        check("t5_rst_busy", 64'(busy), 64'd0);
        check("t5_rst_fsm", 64'(dut.state_q), 64'd0);
        check("t5_rst_gnt", 64'(mem_gnt), 64'd0);
        mem_req = 1'b0;
        rst_n = 1'b1;
        tick();
        exp_q.push_back({1'b0, 32'h600D600D});
        axi_resp.ar_ready = 1'b1;
        mem_issue(1'b0, 16'h0600, '0, 6'h0, g);
        check("t5_gnt_after_rst", 64'(g), 64'd1);
        tick();
        send_r(32'h600D600D, 2'b00);
        tick();
        axi_resp.ar_ready = 1'b0;

        // 6: atomic swap
        axi_resp.aw_ready = 1'b1; axi_resp.w_ready = 1'b1;
`ifdef MEM_TO_AXI_ATOP_EN
        exp_q.push_back({1'b0, 32'h11112222});
        mem_issue(1'b1, 16'h0700, 32'h33334444, 6'h30, g);
        check("t6_aw_atop", 64'(axi_req.aw.atop), 64'h30);
        tick();
        check("t6_both_ready", 64'({axi_req.r_ready, axi_req.b_ready}), 64'b11);
        send_r(32'h11112222, 2'b00);
        check("t6_no_rsp_after_r", 64'(mem_rvalid), 64'd0);
        check("t6_ready_after_r", 64'({axi_req.r_ready, axi_req.b_ready}), 64'b01);
        tick();
        send_b(2'b00);
        check("t6_rsp_after_b", 64'(mem_rvalid), 64'd1);
        tick();
        check("t6_rvalid_pulse", 64'(mem_rvalid), 64'd0);
`else
        exp_q.push_back({1'b0, 32'h0});
        mem_issue(1'b1, 16'h0700, 32'h33334444, 6'h30, g);
        check("t6_aw_atop_off", 64'(axi_req.aw.atop), 64'h0);
        tick();
        check("t6_plain_write", 64'({axi_req.r_ready, axi_req.b_ready}), 64'b01);
        send_b(2'b00);
        check("t6_rsp", 64'(mem_rvalid), 64'd1);
        tick();
`endif
        axi_resp.aw_ready = 1'b0; axi_resp.w_ready = 1'b0;
        tick(); tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        check("final_idle", 64'(busy), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
